// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and MEM/WB operand forwarding.
//   Control in  : clk, rst (async, active-high), stall, flush
//   ID in       : id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_idx, id_rs2_idx,
//                 id_rd_idx, id_aluop, id_a_sel, id_b_sel, id_regwrite, id_is_load
//   Forward in  : mem_regwrite, mem_rd_idx, mem_result, wb_regwrite, wb_rd_idx, wb_data
//   Out         : load_use_stall, ex_valid, ex_pc, ex_aluop, ex_alu_a, ex_alu_b,
//                 ex_store_data, ex_rd_idx, ex_regwrite, ex_is_load
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RIDX-1:0] id_rs1_idx,
  input  logic [RIDX-1:0] id_rs2_idx,
  input  logic [RIDX-1:0] id_rd_idx,
  input  logic [2:0]      id_aluop,
  input  logic            id_a_sel,
  input  logic            id_b_sel,
  input  logic            id_regwrite,
  input  logic            id_is_load,
  input  logic            mem_regwrite,
  input  logic [RIDX-1:0] mem_rd_idx,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwrite,
  input  logic [RIDX-1:0] wb_rd_idx,
  input  logic [XLEN-1:0] wb_data,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [2:0]      ex_aluop,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RIDX-1:0] ex_rd_idx,
  output logic            ex_regwrite,
  output logic            ex_is_load
);
  logic            valid_q, valid_d, cap;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, rs1_d, rs2_d, fwd_rs1, fwd_rs2;
  logic [RIDX-1:0] rs1_idx_q, rs2_idx_q, rd_q;
  logic [2:0]      aluop_q;
  logic            a_sel_q, b_sel_q, regwrite_q, is_load_q;

  // Conservative: either source matching a pending load destination holds ID.
  assign load_use_stall = id_valid & valid_q & is_load_q & (rd_q != '0) &
                          ((id_rs1_idx == rd_q) | (id_rs2_idx == rd_q));

  assign cap     = ~flush & ~stall & ~load_use_stall;
  assign valid_d = flush ? 1'b0 : stall ? valid_q : load_use_stall ? 1'b0 : id_valid;

  // The regfile write in WB lands in the same cycle as the ID read, so take it directly.
  assign rs1_d = (wb_regwrite && wb_rd_idx != '0 && wb_rd_idx == id_rs1_idx) ? wb_data : id_rs1_data;
  assign rs2_d = (wb_regwrite && wb_rd_idx != '0 && wb_rd_idx == id_rs2_idx) ? wb_data : id_rs2_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      rs1_idx_q  <= '0;
      rs2_idx_q  <= '0;
      rd_q       <= '0;
      aluop_q    <= '0;
      a_sel_q    <= 1'b0;
      b_sel_q    <= 1'b0;
      regwrite_q <= 1'b0;
      is_load_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (cap) begin
        pc_q       <= id_pc;
        rs1_q      <= rs1_d;
        rs2_q      <= rs2_d;
        imm_q      <= id_imm;
        rs1_idx_q  <= id_rs1_idx;
        rs2_idx_q  <= id_rs2_idx;
        rd_q       <= id_rd_idx;
        aluop_q    <= id_aluop;
        a_sel_q    <= id_a_sel;
        b_sel_q    <= id_b_sel;
        regwrite_q <= id_regwrite;
        is_load_q  <= id_is_load;
      end
    end
  end

  // MEM is younger than WB, so it wins; x0 always reads its latched value.
  assign fwd_rs1 = (mem_regwrite && rs1_idx_q != '0 && mem_rd_idx == rs1_idx_q) ? mem_result :
                   (wb_regwrite  && rs1_idx_q != '0 && wb_rd_idx  == rs1_idx_q) ? wb_data : rs1_q;
  assign fwd_rs2 = (mem_regwrite && rs2_idx_q != '0 && mem_rd_idx == rs2_idx_q) ? mem_result :
                   (wb_regwrite  && rs2_idx_q != '0 && wb_rd_idx  == rs2_idx_q) ? wb_data : rs2_q;

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_aluop      = aluop_q;
  assign ex_alu_a      = a_sel_q ? pc_q : fwd_rs1;
  assign ex_alu_b      = b_sel_q ? fwd_rs2 : imm_q;
  assign ex_store_data = fwd_rs2;
  assign ex_rd_idx     = rd_q;
  assign ex_regwrite   = valid_q & regwrite_q;
  assign ex_is_load    = valid_q & is_load_q;
endmodule
